// File: rtl/lba_cmd_sequencer.sv
// Splits an inclusive LBA range into chunked host commands; first cmd_valid two cycles after a start edge.
// A command is held stable until cmd_ready; a per-command watchdog bounds the wait for cmd_done.
module lba_cmd_sequencer #(
   parameter int MAX_XFER       = 256,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        start_WR,
   input  logic        start_RD,
   input  logic [47:0] begin_LBA,
   input  logic [47:0] end_LBA,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_write,
   output logic [47:0] cmd_lba,
   output logic [15:0] cmd_count,
   input  logic        cmd_done,
   input  logic        cmd_err,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [48:0] sectors_done
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_DONE, S_ERROR} state_t;

   localparam logic [48:0] MAX49 = 49'(MAX_XFER);
   localparam logic [15:0] MAX16 = 16'(MAX_XFER);
   localparam logic [31:0] TMO   = 32'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic        wr_prev_q, wr_prev_d, rd_prev_q, rd_prev_d;
   logic        valid_q, valid_d, write_q, write_d, bad_q, bad_d;
   logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [1:0]  code_q, code_d;
   logic [47:0] lba_q, lba_d, cur_q, cur_d;
   logic [15:0] count_q, count_d;
   logic [48:0] rem_q, rem_d, sect_q, sect_d;
   logic [31:0] wdog_q, wdog_d;
   logic        wr_edge, rd_edge;
   logic [15:0] chunk;

   assign wr_edge = start_WR & ~wr_prev_q;
   assign rd_edge = start_RD & ~rd_prev_q;
   assign chunk   = (rem_q > MAX49) ? MAX16 : rem_q[15:0];

   always_comb begin
      state_d   = state_q;
      wr_prev_d = start_WR;
      rd_prev_d = start_RD;
      valid_d   = valid_q;
      write_d   = write_q;
      bad_d     = bad_q;
      busy_d    = busy_q;
      done_d    = done_q;
      error_d   = error_q;
      code_d    = code_q;
      lba_d     = lba_q;
      cur_d     = cur_q;
      count_d   = count_q;
      rem_d     = rem_q;
      sect_d    = sect_q;
      wdog_d    = wdog_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (wr_edge || rd_edge) begin
               write_d = wr_edge;
               cur_d   = begin_LBA;
               rem_d   = {1'b0, end_LBA} - {1'b0, begin_LBA} + 49'd1;
               bad_d   = (end_LBA < begin_LBA);
               busy_d  = 1'b1;
               done_d  = 1'b0;
               error_d = 1'b0;
               code_d  = 2'd0;
               sect_d  = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bad_q) begin
               busy_d  = 1'b0;
               error_d = 1'b1;
               code_d  = 2'd1;
               state_d = S_ERROR;
            end else if (!valid_q) begin
               // Load the command one cycle after entering ISSUE so the chunk sees the updated remainder.
               valid_d = 1'b1;
               lba_d   = cur_q;
               count_d = chunk;
            end else if (cmd_ready) begin
               valid_d = 1'b0;
               wdog_d  = '0;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (cmd_done) begin
               if (cmd_err) begin
                  busy_d  = 1'b0;
                  error_d = 1'b1;
                  code_d  = 2'd2;
                  state_d = S_ERROR;
               end else begin
                  cur_d  = cur_q + 48'(count_q);
                  rem_d  = rem_q - 49'(count_q);
                  sect_d = sect_q + 49'(count_q);
                  if (rem_q == 49'(count_q)) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end else if (wdog_q == TMO) begin
               busy_d  = 1'b0;
               error_d = 1'b1;
               code_d  = 2'd3;
               state_d = S_ERROR;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         // History starts high so a switch held through reset is not seen as a press.
         state_q   <= S_IDLE;
         wr_prev_q <= 1'b1;
         rd_prev_q <= 1'b1;
         valid_q   <= 1'b0;
         write_q   <= 1'b0;
         bad_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         code_q    <= 2'd0;
         lba_q     <= '0;
         cur_q     <= '0;
         count_q   <= '0;
         rem_q     <= '0;
         sect_q    <= '0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_prev_q <= wr_prev_d;
         rd_prev_q <= rd_prev_d;
         valid_q   <= valid_d;
         write_q   <= write_d;
         bad_q     <= bad_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         code_q    <= code_d;
         lba_q     <= lba_d;
         cur_q     <= cur_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         sect_q    <= sect_d;
         wdog_q    <= wdog_d;
      end
   end

   assign cmd_valid    = valid_q;
   assign cmd_write    = write_q;
   assign cmd_lba      = lba_q;
   assign cmd_count    = count_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = code_q;
   assign sectors_done = sect_q;

endmodule

// File: tb/tb_lba_cmd_sequencer.sv
// Directed and randomized runs against an arithmetic model of range chunking, completion and watchdog.
module tb_lba_cmd_sequencer;

   localparam int MAXX = 256;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        RST, start_WR, start_RD, cmd_ready, cmd_done, cmd_err;
   logic [47:0] begin_LBA, end_LBA;
   logic        cmd_valid, cmd_write, busy, done, error;
   logic [47:0] cmd_lba;
   logic [15:0] cmd_count;
   logic [1:0]  err_code;
   logic [48:0] sectors_done;

   int checks = 0;
   int errors = 0;

   lba_cmd_sequencer #(.MAX_XFER(MAXX), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .RST(RST), .start_WR(start_WR), .start_RD(start_RD),
      .begin_LBA(begin_LBA), .end_LBA(end_LBA),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_lba(cmd_lba), .cmd_count(cmd_count),
      .cmd_done(cmd_done), .cmd_err(cmd_err),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .sectors_done(sectors_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_write"}, cmd_write, 0);
      chk({tag, "_lba"}, cmd_lba, 0);
      chk({tag, "_count"}, cmd_count, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_code"}, err_code, 0);
      chk({tag, "_sect"}, sectors_done, 0);
   endtask

   // One complete run; the expected command list is derived from the range arithmetic alone.
   task automatic run(input bit wr, input bit rd, input logic [47:0] b, input logic [47:0] e,
                      input int hold0, input int dly, input int err_idx, input int tmo_idx,
                      input bit inject);
      logic [48:0] total, sect, left;
      logic [47:0] exp_lba;
      logic [15:0] exp_cnt;
      int n, guard, hold;
      bit bad;
      bad   = (e < b);
      total = {1'b0, e} - {1'b0, b} + 49'd1;
      n     = bad ? 0 : int'((total + 49'(MAXX - 1)) / 49'(MAXX));
      sect  = '0;
      start_WR = 1'b0; start_RD = 1'b0;
      tick();
      begin_LBA = b; end_LBA = e; start_WR = wr; start_RD = rd;
      tick();
      chk("start_busy", busy, 1);
      chk("start_valid", cmd_valid, 0);
      chk("start_sect", sectors_done, 0);
      chk("start_clr_err", error, 0);
      start_WR = 1'b0; start_RD = 1'b0;
      tick();
      if (bad) begin
         chk("bad_error", error, 1);
         chk("bad_code", err_code, 1);
         chk("bad_busy", busy, 0);
         chk("bad_valid", cmd_valid, 0);
         repeat (3) begin
            tick();
            chk("bad_novalid", cmd_valid, 0);
         end
         return;
      end
      chk("first_valid_latency", cmd_valid, 1);
      for (int i = 0; i < n; i++) begin
         exp_lba = b + 48'(i) * 48'(MAXX);
         left    = total - 49'(i) * 49'(MAXX);
         exp_cnt = (left > 49'(MAXX)) ? 16'(MAXX) : left[15:0];
         guard = 0;
         while (!cmd_valid && guard < 8) begin
            tick();
            guard++;
         end
         chk("cmd_valid", cmd_valid, 1);
         chk("cmd_lba", cmd_lba, exp_lba);
         chk("cmd_count", cmd_count, exp_cnt);
         chk("cmd_write", cmd_write, wr);
         hold = (i == 0) ? hold0 : int'($urandom_range(0, 3));
         cmd_ready = 1'b0;
         repeat (hold) begin
            cmd_done = 1'($urandom_range(0, 1));
            cmd_err  = 1'b1;
            tick();
            chk("hold_valid", cmd_valid, 1);
            chk("hold_lba", cmd_lba, exp_lba);
            chk("hold_count", cmd_count, exp_cnt);
            chk("hold_noerr", error, 0);
         end
         cmd_ready = 1'b1; cmd_done = 1'b1; cmd_err = 1'b0;
         tick();
         cmd_ready = 1'b0; cmd_done = 1'b0; cmd_err = 1'b0;
         chk("hs_valid_drop", cmd_valid, 0);
         chk("hs_sect_unchanged", sectors_done, sect);
         if (inject && i == 0) begin
            start_WR = 1'b1; start_RD = 1'b1;
         end
         if (i == tmo_idx) begin
            for (int j = 1; j <= TMO + 1; j++) begin
               tick();
               chk("tmo_error_timing", error, (j == TMO + 1) ? 1 : 0);
            end
            chk("tmo_code", err_code, 3);
            chk("tmo_busy", busy, 0);
            chk("tmo_sect", sectors_done, sect);
            return;
         end
         repeat (dly - 1) tick();
         cmd_done = 1'b1;
         cmd_err  = (i == err_idx);
         tick();
         cmd_done = 1'b0; cmd_err = 1'b0;
         if (i == err_idx) begin
            chk("dev_error", error, 1);
            chk("dev_code", err_code, 2);
            chk("dev_busy", busy, 0);
            chk("dev_sect", sectors_done, sect);
            return;
         end
         sect = sect + 49'(exp_cnt);
         chk("run_sect", sectors_done, sect);
      end
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_error", error, 0);
      chk("end_code", err_code, 0);
      chk("end_sect", sectors_done, total);
   endtask

   initial begin
      logic [47:0] rb;
      int len, e_idx;
      bit rw;
      RST = 1'b1; start_WR = 1'b0; start_RD = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0; cmd_err = 1'b0;
      begin_LBA = '0; end_LBA = '0;
      repeat (3) tick();
      chk_reset_vals("reset");
      RST = 1'b0;

      run(1, 0, 48'h100, 48'h2FF, 0, 5, -1, -1, 0);
      run(0, 1, 48'd10, 48'd10, 0, 5, -1, -1, 0);
      run(0, 1, 48'd0, 48'd599, 0, 3, -1, -1, 1);
      run(1, 0, 48'h50, 48'h4F, 0, 5, -1, -1, 0);
      run(1, 0, 48'h1000, 48'h13FF, 20, 4, 1, -1, 0);
      run(0, 1, 48'h7000, 48'h70FF, 0, 1, -1, 0, 0);
      run(1, 0, 48'h9000, 48'h91FF, 0, TMO + 1, -1, -1, 0);
      run(1, 1, 48'h20, 48'h3F, 0, 2, -1, -1, 0);
      run(0, 1, 48'hFFFF_FFFF_FED4, 48'hFFFF_FFFF_FFFF, 0, 2, -1, -1, 0);

      for (int k = 0; k < 10; k++) begin
         rb    = {8'h0, 8'($urandom), 32'($urandom)};
         len   = int'($urandom_range(1, 800));
         rw    = 1'($urandom_range(0, 1));
         e_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
         run(rw, ~rw | 1'($urandom_range(0, 1)), rb, rb + 48'(len - 1),
             int'($urandom_range(0, 5)), int'($urandom_range(1, TMO + 1)),
             e_idx, ($urandom_range(0, 7) == 0) ? 0 : -1, 1'($urandom_range(0, 1)));
      end

      start_WR = 1'b1; start_RD = 1'b1; RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      repeat (4) begin
         tick();
         chk("held_busy", busy, 0);
         chk("held_valid", cmd_valid, 0);
      end
      start_WR = 1'b0; start_RD = 1'b0;
      tick();
      begin_LBA = 48'd0; end_LBA = 48'd1000; start_WR = 1'b1;
      repeat (2) tick();
      chk("mid_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      tick();
      chk("mid_wait_busy", busy, 1);
      RST = 1'b1;
      tick();
      chk_reset_vals("mid_reset");
      RST = 1'b0; start_WR = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/lba_cmd_sequencer.md
Name: lba_cmd_sequencer

Overview:
Consumes the write/read start requests and the LBA range produced by the front-panel switch control block. Splits the inclusive range [begin_LBA, end_LBA] into sector-chunked commands for the SATA host command layer, using a valid/ready issue handshake and a done/err completion handshake. Reports busy, done and error status, plus a running sector count, back toward the control and display logic.

Parameters:
MAX_XFER, 256, maximum sectors per issued command; legal range 1..65535
TIMEOUT_CYCLES, 50000000, completion watchdog in clk cycles, counted from the issue handshake; legal range >= 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
RST  input  1  synchronous, active-high reset
start_WR  input  1  write request level; a rising edge starts a write run
start_RD  input  1  read request level; a rising edge starts a read run
begin_LBA  input  48  first LBA of the run; sampled on the start edge
end_LBA  input  48  last LBA of the run (inclusive); sampled on the start edge
cmd_valid  output  1  command presented to the host layer
cmd_ready  input  1  host layer accepts the command
cmd_write  output  1  1 = write, 0 = read
cmd_lba  output  48  starting LBA of the current command
cmd_count  output  16  sector count of the current command
cmd_done  input  1  single-cycle completion pulse from the host layer
cmd_err  input  1  error qualifier; valid only when cmd_done=1
busy  output  1  a run is in progress
done  output  1  the last run completed without error
error  output  1  the last run ended in error
err_code  output  2  0 = none, 1 = bad range, 2 = device error, 3 = timeout
sectors_done  output  49  sectors completed in the current or last run

Behaviour:
- Reset (RST=1 at a clk edge): state=IDLE; cmd_valid=0, cmd_write=0, cmd_lba=0, cmd_count=0, busy=0, done=0, error=0, err_code=0, sectors_done=0; the edge-detect history registers for start_WR/start_RD are set to 1. A switch held through reset therefore does not start a run; it must be released and pressed again. Reset mid-run drops cmd_valid on the next edge with no cleanup.
- Start edge: current input=1 and previous sample=0. Start edges are accepted only in IDLE, DONE or ERROR; they are ignored while busy. If both edges occur in the same cycle, the write wins.
- On an accepted start:
  - Latch cmd_write, begin/end and cur_lba=begin.
  - Compute remaining = end - begin + 1, 49 bits wide; the full 2^48 range is legal.
  - Clear done, error, err_code and sectors_done; set busy=1.
  - If end < begin: go to ERROR with err_code=1 on the next cycle; no command is issued.
- States: IDLE, ISSUE, WAIT_DONE, DONE, ERROR.
- ISSUE:
  - cmd_valid=1, cmd_lba=cur_lba, cmd_count=min(remaining, MAX_XFER).
  - All cmd_* fields stay stable until the cycle where cmd_valid and cmd_ready are both 1 (the handshake). The next state is then WAIT_DONE, with cmd_valid=0 in the following cycle.
  - First cmd_valid rises 2 cycles after the start edge appears on the input pins.
- WAIT_DONE:
  - The watchdog clears at the handshake and increments each cycle.
  - cmd_done=1 with cmd_err=1: go to ERROR, err_code=2.
  - cmd_done=1 with cmd_err=0: cur_lba += count, remaining -= count, sectors_done += count. If remaining is then 0, go to DONE; otherwise go to ISSUE.
  - If cmd_done and the watchdog limit occur in the same cycle, cmd_done wins.
  - Watchdog reaching TIMEOUT_CYCLES: go to ERROR, err_code=3; error asserts TIMEOUT_CYCLES+1 cycles after the handshake edge.
- cmd_done while in IDLE, ISSUE, DONE or ERROR is ignored, including on the handshake cycle itself.
- DONE: busy=0, done=1, held until the next accepted start or reset.
- ERROR: busy=0, error=1, err_code held, until the next accepted start or reset. sectors_done keeps the count completed before the failure.
- cur_lba is 48-bit; its post-run wrap past 2^48-1 is never issued and is don't-care.
- All outputs are registered.

Test Plan:
- Write run, begin=0x100, end=0x2FF, MAX_XFER=256, ready always 1, done 5 cycles after each handshake: commands (lba 0x100, count 256, write=1) then (0x200, 256); done=1, busy=0, sectors_done=512.
- Read run, begin=10, end=10: one command (lba 10, count 1, write=0); done=1, sectors_done=1. Range 0..599 with MAX_XFER=256 yields counts 256, 256, 88.
- Bad range, begin=0x50, end=0x4F: error=1, err_code=1, cmd_valid never asserts. A start edge during a busy run is ignored and the run completes unchanged.
- Backpressure: cmd_ready held 0 for 20 cycles keeps cmd_valid/lba/count stable; cmd_done with cmd_err=1 gives err_code=2 with sectors_done unchanged.
- TIMEOUT_CYCLES=16, no cmd_done: error=1, err_code=3 exactly 17 cycles after the handshake; cmd_done coincident with the limit still completes normally.
- start_WR and start_RD rise together: cmd_write=1. Switch held through RST: no run starts. RST in WAIT_DONE: cmd_valid=0 and all outputs return to reset values next edge.
